topk_stream_packer: RTL and testbench

- Upstream feeder for the top-k pairwise selector stage.
- Accepts a serial stream of IEEE-754 single-precision scores, one per beat, with valid/ready handshake.
- Packs them into pairs of N-lane vectors (x_0, x_1) and presents each pair as one output transaction.
- Ping-pong banking keeps the input streaming while the previous pair waits for the selector; frame tails are padded with -inf so padding can never enter a top-k result.

---
 rtl/topk_stream_packer_pkg.sv | 21 ++
 rtl/topk_stream_packer_if.sv | 34 +++
 rtl/topk_pack_bank.sv | 82 ++++++++
 rtl/topk_stream_packer.sv | 90 +++++++++
 tb/tb_topk_stream_packer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/topk_stream_packer_pkg.sv
// rtl/topk_stream_packer_pkg.sv - shared constants and lane helpers for the top-k packer/selector
package topk_stream_packer_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_LOG_INPUT_NUM = 4;

    // FP32 infinities; NEG_INF is the pad so padding always loses a top-k compare.
    localparam logic [31:0] NEG_INF = 32'hFF800000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    // Lanes per vector for a given log2 lane count.
    function automatic int lanes(input int log_input_num);
        return 1 << log_input_num;
    endfunction

    // Lane i occupies [width*(i+1)-1 -: width], i.e. starts at bit width*i.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/topk_stream_packer_if.sv
// rtl/topk_stream_packer_if.sv - element input stream and packed-pair output bundle
// Signals:
//   i_valid/i_ready/i_data/i_last : serial element stream into the packer
//   o_valid/o_ready/x_0/x_1/o_last: packed pair stream out of the packer
// Modports: slave = packer side, master = feeder/consumer side.
interface topk_stream_packer_if
    import topk_stream_packer_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int LOG_INPUT_NUM = DEF_LOG_INPUT_NUM
);
    localparam int N = lanes(LOG_INPUT_NUM);

    logic                    i_valid;
    logic                    i_ready;
    logic [DATA_WIDTH-1:0]   i_data;
    logic                    i_last;
    logic                    o_valid;
    logic                    o_ready;
    logic [DATA_WIDTH*N-1:0] x_0;
    logic [DATA_WIDTH*N-1:0] x_1;
    logic                    o_last;

    modport slave (
        input  i_valid, i_data, i_last, o_ready,
        output i_ready, o_valid, x_0, x_1, o_last
    );

    modport master (
        output i_valid, i_data, i_last, o_ready,
        input  i_ready, o_valid, x_0, x_1, o_last
    );

endinterface

// File: rtl/topk_pack_bank.sv
// rtl/topk_pack_bank.sv - one 2N-slot packing bank with fill count, close flag and padded read view
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the bank)
//   wr_en_i      : write wr_data_i into slot cnt (only issued while not full)
//   wr_data_i    : element to store
//   wr_last_i    : element ends a frame; closes the bank
//   clr_i        : bank consumed downstream; empty it (only issued while full)
//   full_o       : bank closed and waiting to be read
//   last_o       : closing beat carried i_last
//   closing_o    : this cycle's write closes the bank
//   x0_o, x1_o   : slots 0..N-1 and N..2N-1, unwritten slots shown as PAD_VALUE
module topk_pack_bank
    import topk_stream_packer_pkg::*;
#(
    parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int                    LOG_INPUT_NUM = DEF_LOG_INPUT_NUM,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = NEG_INF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      wr_en_i,
    input  logic [DATA_WIDTH-1:0]                     wr_data_i,
    input  logic                                      wr_last_i,
    input  logic                                      clr_i,
    output logic                                      full_o,
    output logic                                      last_o,
    output logic                                      closing_o,
    output logic [DATA_WIDTH*lanes(LOG_INPUT_NUM)-1:0] x0_o,
    output logic [DATA_WIDTH*lanes(LOG_INPUT_NUM)-1:0] x1_o
);
    localparam int N  = lanes(LOG_INPUT_NUM);
    localparam int CW = LOG_INPUT_NUM + 2;
    localparam int AW = LOG_INPUT_NUM + 1;
    localparam logic [CW-1:0] CAP = CW'(2 * N);

    logic [DATA_WIDTH-1:0] mem_q [2*N];
    logic [CW-1:0]         cnt_q;
    logic                  full_q;
    logic                  last_q;

    assign closing_o = wr_en_i && (((cnt_q + CW'(1)) == CAP) || wr_last_i);
    assign full_o    = full_q;
    assign last_o    = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            last_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            last_q <= 1'b0;
        end else if (wr_en_i) begin
            cnt_q <= cnt_q + CW'(1);
            if (closing_o) begin
                full_q <= 1'b1;
                last_q <= wr_last_i;
            end
        end
    end

    // Data needs no reset: every slot at or above cnt is masked to PAD_VALUE.
    // Writes only happen while cnt < 2N, so the low AW bits address the slot.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[cnt_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_comb begin
        x0_o = '0;
        x1_o = '0;
        for (int j = 0; j < N; j++) begin
            x0_o[lane_lo(j, DATA_WIDTH) +: DATA_WIDTH] =
                (CW'(j) < cnt_q) ? mem_q[j] : PAD_VALUE;
            x1_o[lane_lo(j, DATA_WIDTH) +: DATA_WIDTH] =
                (CW'(j + N) < cnt_q) ? mem_q[j + N] : PAD_VALUE;
        end
    end

endmodule

// File: rtl/topk_stream_packer.sv
// rtl/topk_stream_packer.sv - ping-pong packer of a serial FP32 stream into N-lane vector pairs
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset; discards partial and pending banks
//   bus  : slave side of topk_stream_packer_if
//          i_valid/i_ready/i_data/i_last in, o_valid/o_ready/x_0/x_1/o_last out
// Two banks alternate: wr fills one while rd presents the other, so input
// keeps streaming while a closed pair waits for the selector.
module topk_stream_packer
    import topk_stream_packer_pkg::*;
#(
    parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int                    LOG_INPUT_NUM = DEF_LOG_INPUT_NUM,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = NEG_INF
) (
    input  logic                    clk,
    input  logic                    rst,
    topk_stream_packer_if.slave     bus
);
    localparam int N  = lanes(LOG_INPUT_NUM);
    localparam int VW = DATA_WIDTH * N;

    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic          accept;
    logic          drain;
    logic          show;
    logic          wr_en   [2];
    logic          clr     [2];
    logic          full    [2];
    logic          last    [2];
    logic          closing [2];
    logic [VW-1:0] view0   [2];
    logic [VW-1:0] view1   [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        topk_pack_bank #(
            .DATA_WIDTH    (DATA_WIDTH),
            .LOG_INPUT_NUM (LOG_INPUT_NUM),
            .PAD_VALUE     (PAD_VALUE)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en[b]),
            .wr_data_i (bus.i_data),
            .wr_last_i (bus.i_last),
            .clr_i     (clr[b]),
            .full_o    (full[b]),
            .last_o    (last[b]),
            .closing_o (closing[b]),
            .x0_o      (view0[b]),
            .x1_o      (view1[b])
        );
    end

    // Ready comes only from registered bank state, never from i_valid.
    assign accept = bus.i_valid && !full[wr_q];
    // Outputs are forced to zero while reset is asserted or no pair is ready.
    assign show   = full[rd_q] && !rst;
    assign drain  = show && bus.o_ready;

    always_comb begin
        wr_en[0] = 1'b0;
        wr_en[1] = 1'b0;
        clr[0]   = 1'b0;
        clr[1]   = 1'b0;
        wr_en[wr_q] = accept;
        clr[rd_q]   = drain;
        // Closing and draining are independent, so both pointers may move together.
        wr_d = wr_q ^ (closing[0] || closing[1]);
        rd_d = rd_q ^ drain;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    assign bus.i_ready = !full[wr_q];
    assign bus.o_valid = show;
    assign bus.o_last  = show && last[rd_q];
    assign bus.x_0     = show ? view0[rd_q] : '0;
    assign bus.x_1     = show ? view1[rd_q] : '0;

endmodule

// File: tb/tb_topk_stream_packer.sv
// tb/tb_topk_stream_packer.sv - self-checking bench for topk_stream_packer
module tb_topk_stream_packer;
    import topk_stream_packer_pkg::*;

    localparam int DW = 32;
    localparam int LG = 4;
    localparam int N  = 16;
    localparam int VW = DW * N;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    typedef struct {
        logic [VW-1:0] x0;
        logic [VW-1:0] x1;
        logic          l;
    } pair_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    topk_stream_packer_if #(.DATA_WIDTH(DW), .LOG_INPUT_NUM(LG)) bus ();

    topk_stream_packer #(
        .DATA_WIDTH    (DW),
        .LOG_INPUT_NUM (LG),
        .PAD_VALUE     (NEG_INF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t         in_q [$];
    logic [DW-1:0] cur  [$];
    pair_t         pq   [$];
    int            checks = 0;
    int            errors = 0;
    bit            gaps   = 1'b0;
    int            rmode  = 0;

    // Integer 1..255 to FP32 bit pattern.
    function automatic logic [31:0] fp(input int k);
        int e;
        e = 0;
        while ((k >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((k - (1 << e)) << (23 - e))};
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // A closed frame chunk: real elements in slot order, the rest -inf.
    task automatic close_frame(input logic lst);
        pair_t         p;
        logic [DW-1:0] v;
        p.x0 = '0;
        p.x1 = '0;
        for (int s = 0; s < 2 * N; s++) begin
            v = (s < cur.size()) ? cur[s] : NEG_INF;
            if (s < N) p.x0[s*DW +: DW] = v;
            else       p.x1[(s-N)*DW +: DW] = v;
        end
        p.l = lst;
        pq.push_back(p);
        cur.delete();
    endtask

    task automatic step();
        bit    exp_rdy;
        bit    acc;
        bit    drn;
        beat_t b;
        if (!rst && in_q.size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
            bus.i_valid = 1'b1;
            bus.i_data  = in_q[0].d;
            bus.i_last  = in_q[0].l;
        end else begin
            bus.i_valid = 1'b0;
            bus.i_data  = $urandom;
            bus.i_last  = 1'($urandom_range(0, 1));
        end
        case (rmode)
            0:       bus.o_ready = 1'b1;
            1:       bus.o_ready = 1'b0;
            default: bus.o_ready = ($urandom_range(0, 2) != 0);
        endcase
        @(negedge clk);
        exp_rdy = (pq.size() < 2);
        if (rst) begin
            chk("rst_o_valid", VW'(bus.o_valid), '0);
            chk("rst_o_last",  VW'(bus.o_last),  '0);
            chk("rst_x_0",     bus.x_0,          '0);
            chk("rst_x_1",     bus.x_1,          '0);
        end else begin
            chk("i_ready", VW'(bus.i_ready), VW'(exp_rdy));
            chk("o_valid", VW'(bus.o_valid), VW'(pq.size() > 0));
            if (pq.size() > 0) begin
                chk("x_0",    bus.x_0,         pq[0].x0);
                chk("x_1",    bus.x_1,         pq[0].x1);
                chk("o_last", VW'(bus.o_last), VW'(pq[0].l));
            end else begin
                chk("idle_x_0",   bus.x_0,         '0);
                chk("idle_x_1",   bus.x_1,         '0);
                chk("idle_olast", VW'(bus.o_last), '0);
            end
        end
        acc = !rst && bus.i_valid && exp_rdy;
        drn = !rst && (pq.size() > 0) && bus.o_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            pq.delete();
            cur.delete();
        end else begin
            if (drn) void'(pq.pop_front());
            if (acc) begin
                b = in_q.pop_front();
                cur.push_back(b.d);
                if (b.l || cur.size() == 2 * N) close_frame(b.l);
            end
        end
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((in_q.size() > 0 || pq.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("timeout", VW'(n < budget), VW'(1));
    endtask

    task automatic push_seq(input int first, input int count, input bit last_at_end);
        beat_t b;
        for (int k = 0; k < count; k++) begin
            b.d = fp(first + k);
            b.l = last_at_end && (k == count - 1);
            in_q.push_back(b);
        end
    endtask

    initial begin
        beat_t b;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_last  = 1'b0;
        bus.o_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_i_ready", VW'(bus.i_ready), VW'(1));

        // Full pair, no last.
        rmode = 0;
        push_seq(1, 32, 1'b0);
        run_idle(200);

        // Short frame of 5.
        push_seq(1, 5, 1'b1);
        run_idle(200);

        // Backpressure: both banks fill, one drain, input resumes.
        rmode = 1;
        push_seq(1, 70, 1'b1);
        repeat (80) step();
        chk("bp_accepted", VW'(in_q.size()), VW'(6));
        rmode = 0;
        step();
        rmode = 1;
        repeat (3) step();
        chk("bp_resumed", VW'(in_q.size()), VW'(3));
        rmode = 0;
        run_idle(300);

        // Streaming 96 beats.
        push_seq(1, 96, 1'b0);
        run_idle(300);

        // Single-element frame then full frame.
        push_seq(7, 1, 1'b1);
        push_seq(1, 32, 1'b0);
        run_idle(300);

        // Reset mid-frame.
        push_seq(1, 10, 1'b0);
        run_idle(100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_seq(100, 32, 1'b0);
        run_idle(200);

        // Randomized traffic.
        gaps  = 1'b1;
        rmode = 2;
        for (int k = 0; k < 600; k++) begin
            b.d = $urandom;
            b.l = ($urandom_range(0, 9) == 0);
            in_q.push_back(b);
        end
        run_idle(5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
